// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen_if
//  Description : Pixel-path bundle between the raster timing generator and
//                its consumer (panel pins / renderer). The master modport is
//                the generator side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic [1:0]    mode_i;
    logic [23:0]   color_i;
    logic [23:0]   rgb_i;
    logic [23:0]   vid_rgb_o;
    logic [2:0]    dvh_sync_o;
    logic [CW-1:0] x_o;
    logic [CW-1:0] y_o;
    logic          frame_start_o;
    logic          line_start_o;
    logic [15:0]   frame_cnt_o;

    modport master (
        input  mode_i, color_i, rgb_i,
        output vid_rgb_o, dvh_sync_o, x_o, y_o, frame_start_o, line_start_o, frame_cnt_o
    );

    modport slave (
        output mode_i, color_i, rgb_i,
        input  vid_rgb_o, dvh_sync_o, x_o, y_o, frame_start_o, line_start_o, frame_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing generator for the LCD panel path. Produces
//                {DE, VSync, HSync} with programmable polarity, pixel
//                coordinates, frame/line strobes and a frame counter. All
//                timing outputs are registered one cycle after the raster
//                counters.
//                Optional macro TEST_PATTERN_EN builds an internal pattern
//                source (solid / bars / checker / gradient); without it the
//                external rgb_i is gated by DE.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_RES    = 800,
    parameter int H_FP     = 40,
    parameter int H_PW     = 48,
    parameter int H_BP     = 40,
    parameter int V_RES    = 480,
    parameter int V_FP     = 13,
    parameter int V_PW     = 3,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12,
    parameter int CHK_LOG2 = 4
) (
    input  wire                clk_i,
    input  wire                rst_i,
    video_timing_gen_if.master vif
);

    localparam int c_H_TOTAL  = H_RES + H_FP + H_PW + H_BP;
    localparam int c_V_TOTAL  = V_RES + V_FP + V_PW + V_BP;

    localparam logic [CW-1:0] c_H_LAST     = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_RES      = CW'(H_RES);
    localparam logic [CW-1:0] c_V_RES      = CW'(V_RES);
    localparam logic [CW-1:0] c_HS_START   = CW'(H_RES + H_FP);
    localparam logic [CW-1:0] c_HS_END     = CW'(H_RES + H_FP + H_PW);
    localparam logic [CW-1:0] c_VS_START   = CW'(V_RES + V_FP);
    localparam logic [CW-1:0] c_VS_END     = CW'(V_RES + V_FP + V_PW);

    // Counters must be able to hold every raster position.
    generate
        if (c_H_TOTAL > (2 ** CW)) begin : g_err_h_total
            $error("video_timing_gen: H_TOTAL does not fit in CW bits");
        end
        if (c_V_TOTAL > (2 ** CW)) begin : g_err_v_total
            $error("video_timing_gen: V_TOTAL does not fit in CW bits");
        end
        if (CHK_LOG2 >= CW) begin : g_err_chk
            $error("video_timing_gen: CHK_LOG2 must index a coordinate bit");
        end
    endgenerate

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [15:0]   r_frame_cnt;
    logic          r_de;
    logic          r_hs;
    logic          r_vs;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_frame_start;
    logic          r_line_start;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_frame_origin;
    logic w_de;
    logic w_hs_act;
    logic w_vs_act;

    assign w_h_wrap       = (r_h_cnt == c_H_LAST);
    assign w_v_wrap       = (r_v_cnt == c_V_LAST);
    assign w_frame_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_de           = (r_h_cnt < c_H_RES) && (r_v_cnt < c_V_RES);
    assign w_hs_act       = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign w_vs_act       = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

    // Raster position: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Timing outputs describe the position held by the counters last cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_de          <= 1'b0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_de          <= w_de;
            r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_frame_start <= w_frame_origin;
            r_line_start  <= (r_h_cnt == '0) && (r_v_cnt < c_V_RES);
        end
    end

    // Completed frames: bump on the clock where both counters return to 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame_cnt <= '0;
        end else if (w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign vif.dvh_sync_o    = {r_de, r_vs, r_hs};
    assign vif.x_o           = r_x;
    assign vif.y_o           = r_y;
    assign vif.frame_start_o = r_frame_start;
    assign vif.line_start_o  = r_line_start;
    assign vif.frame_cnt_o   = r_frame_cnt;

`ifdef TEST_PATTERN_EN
    // Bar width; a panel narrower than 8 pixels degenerates to 1-pixel bars.
    localparam int            c_BAR_W_RAW = H_RES / 8;
    localparam int            c_BAR_W     = (c_BAR_W_RAW > 0) ? c_BAR_W_RAW : 1;
    localparam logic [CW-1:0] c_BAR_LAST  = CW'(c_BAR_W - 1);

    logic [1:0]    r_mode;
    logic [CW-1:0] r_bar_run;
    logic [2:0]    r_bar_idx;
    logic [23:0]   r_rgb;
    logic [1:0]    w_mode;
    logic [23:0]   w_bar_rgb;
    logic [23:0]   w_pattern;
    logic          w_chk;
    logic          w_unused_rgb;

    // Pixel (0,0) already uses the freshly sampled mode so a frame never mixes modes.
    assign w_mode       = w_frame_origin ? vif.mode_i : r_mode;
    assign w_chk        = r_h_cnt[CHK_LOG2] ^ r_v_cnt[CHK_LOG2];
    assign w_unused_rgb = ^vif.rgb_i;

    // Mode shadow, reloaded once per frame at the origin.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode <= 2'd0;
        end else if (w_frame_origin) begin
            r_mode <= vif.mode_i;
        end
    end

    // Bar index follows h via a run-length counter; bar 7 takes the remainder.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_h_wrap) begin
            r_bar_run <= '0;
            r_bar_idx <= 3'd0;
        end else if ((r_bar_run == c_BAR_LAST) && (r_bar_idx != 3'd7)) begin
            r_bar_run <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_run <= r_bar_run + 1'b1;
        end
    end

    // Colour-bar palette.
    always_comb begin
        w_bar_rgb = 24'h000000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    // Pattern selection for the current raster position.
    always_comb begin
        w_pattern = vif.color_i;
        case (w_mode)
            2'd0:    w_pattern = vif.color_i;
            2'd1:    w_pattern = w_bar_rgb;
            2'd2:    w_pattern = w_chk ? 24'hFFFFFF : 24'h000000;
            default: w_pattern = {8'(r_h_cnt), 8'(r_v_cnt), r_frame_cnt[7:0]};
        endcase
    end

    // Registered pixel, blanked outside the active area.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rgb <= 24'd0;
        end else begin
            r_rgb <= w_de ? w_pattern : 24'd0;
        end
    end

    assign vif.vid_rgb_o = r_rgb;
`else
    logic w_unused_cfg;

    // External pixel is combinational so it lines up with the presented x/y.
    assign vif.vid_rgb_o = r_de ? vif.rgb_i : 24'd0;
    assign w_unused_cfg  = ^{vif.mode_i, vif.color_i};
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen using small raster
//                parameters and an arithmetic reference model driven by the
//                pixel index since the last reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int H_RES = 8, H_FP = 2, H_PW = 3, H_BP = 1;
    localparam int V_RES = 4, V_FP = 1, V_PW = 2, V_BP = 1;
    localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
    localparam int CW = 12, CHK_LOG2 = 1;
    localparam int H_TOTAL = H_RES + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_PW + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int BAR_W   = (H_RES / 8 > 0) ? H_RES / 8 : 1;
    localparam int OW      = 3 + 2 * CW + 2 + 24 + 16;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk;
    logic rst;
    video_timing_gen_if #(.CW(CW)) vif ();

    video_timing_gen #(
        .H_RES(H_RES), .H_FP(H_FP), .H_PW(H_PW), .H_BP(H_BP),
        .V_RES(V_RES), .V_FP(V_FP), .V_PW(V_PW), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .CHK_LOG2(CHK_LOG2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .vif   (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [OW-1:0] obs;
    assign obs = {vif.dvh_sync_o, vif.x_o, vif.y_o, vif.frame_start_o,
                  vif.line_start_o, vif.vid_rgb_o, vif.frame_cnt_o};

    int          checks   = 0;
    int          failures = 0;
    int          m_p      = -1;       // pixel index presented now, -1 = reset state
    logic [15:0] m_fc     = 16'd0;
    logic [1:0]  m_mode   = 2'd0;
    logic [23:0] m_col    = 24'd0;
    logic [OW-1:0] e_all;
    bit          rand_color = 1'b1;

    // Expected outputs for pixel index p of the raster since reset.
    function automatic logic [OW-1:0] model_out(int p, logic [15:0] fc, logic [1:0] md,
                                                logic [23:0] col, logic [23:0] rgb);
        int h, v, bar;
        logic de, hs, vs, fs, ls;
        logic [23:0] pix;
        if (p < 0)
            return {1'b0, ~VS_POL, ~HS_POL, {CW{1'b0}}, {CW{1'b0}}, 2'b00, 24'd0, fc};
        h  = p % H_TOTAL;
        v  = (p / H_TOTAL) % V_TOTAL;
        de = (h < H_RES) && (v < V_RES);
        hs = (h >= H_RES + H_FP && h < H_RES + H_FP + H_PW) ? HS_POL : ~HS_POL;
        vs = (v >= V_RES + V_FP && v < V_RES + V_FP + V_PW) ? VS_POL : ~VS_POL;
        fs = (h == 0) && (v == 0);
        ls = (h == 0) && (v < V_RES);
`ifdef TEST_PATTERN_EN
        bar = h / BAR_W;
        if (bar > 7) bar = 7;
        case (md)
            2'd0:    pix = col;
            2'd1:    pix = BARS[bar];
            2'd2:    pix = (((h >> CHK_LOG2) ^ (v >> CHK_LOG2)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            default: pix = {8'(h), 8'(v), fc[7:0]};
        endcase
        if (!de) pix = 24'd0;
`else
        bar = 0;
        pix = (de && (bar == 0)) ? rgb : 24'd0;
`endif
        return {de, vs, hs, CW'(h), CW'(v), fs, ls, pix, fc};
    endfunction

    // One clock: randomize live inputs, advance the model, sample 1 unit after the edge.
    task automatic tick();
        logic [1:0]  md;
        logic [23:0] col;
        logic        r;
        if (rand_color) vif.color_i = 24'($urandom);
        vif.rgb_i = 24'($urandom);
        md  = vif.mode_i;
        col = vif.color_i;
        r   = rst;
        @(posedge clk);
        if (r) begin
            m_p = -1; m_fc = 16'd0; m_mode = 2'd0;
        end else begin
            m_p++;
            if (m_p % FRAME == 0) m_mode = md;
            if (m_p % FRAME == FRAME - 1) m_fc++;
            m_col = col;
        end
        #1;
        e_all = model_out(m_p, m_fc, m_mode, m_col, vif.rgb_i);
    endtask

    task automatic apply_reset(int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL reset_state got=%h exp=%h", obs, e_all);
            end
        end
        checks++;
        if ({vif.dvh_sync_o, vif.vid_rgb_o} !== {3'b011, 24'd0}) begin
            failures++;
            $display("FAIL reset_pins got=%b/%h exp=011/000000", vif.dvh_sync_o, vif.vid_rgb_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({vif.dvh_sync_o[2], vif.x_o, vif.y_o, vif.frame_start_o} !== {1'b1, 12'd0, 12'd0, 1'b1}) begin
            failures++;
            $display("FAIL first_pixel got de=%b x=%0d y=%0d fs=%b exp de=1 x=0 y=0 fs=1",
                     vif.dvh_sync_o[2], vif.x_o, vif.y_o, vif.frame_start_o);
        end
    endtask

    task automatic test_line();
        int de_cnt = 0, ls_cnt = 0;
        logic [H_TOTAL-1:0] hs_low = '0;
        for (int i = 0; i < H_TOTAL; i++) begin
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL line_pixel p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
            if (vif.dvh_sync_o[2]) de_cnt++;
            if (vif.line_start_o) ls_cnt++;
            if (!vif.dvh_sync_o[0]) hs_low[vif.x_o] = 1'b1;
            tick();
        end
        checks++;
        if (de_cnt !== 8) begin
            failures++; $display("FAIL line_de_count got=%0d exp=8", de_cnt);
        end
        checks++;
        if (hs_low !== 14'h1C00) begin
            failures++; $display("FAIL line_hsync_pos got=%b exp=%b", hs_low, 14'h1C00);
        end
        checks++;
        if (ls_cnt !== 1) begin
            failures++; $display("FAIL line_start_count got=%0d exp=1", ls_cnt);
        end
    endtask

    task automatic test_frame();
        int vs_cnt = 0, ls_cnt = 0, fs_n = 0;
        int fs_t [2];
        apply_reset(2);
        for (int t = 1; t <= 2 * FRAME; t++) begin
            tick();
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL frame_pixel p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
            if (t <= FRAME && !vif.dvh_sync_o[1]) vs_cnt++;
            if (t <= FRAME && vif.line_start_o) ls_cnt++;
            if (vif.frame_start_o && fs_n < 2) begin fs_t[fs_n] = t; fs_n++; end
            if (t == FRAME) begin
                checks++;
                if (vif.frame_cnt_o !== 16'd1) begin
                    failures++; $display("FAIL frame_cnt_after_112 got=%0d exp=1", vif.frame_cnt_o);
                end
            end
        end
        checks++;
        if (vs_cnt !== 28) begin
            failures++; $display("FAIL vsync_width got=%0d exp=28", vs_cnt);
        end
        checks++;
        if (ls_cnt !== 4) begin
            failures++; $display("FAIL line_starts_per_frame got=%0d exp=4", ls_cnt);
        end
        checks++;
        if (fs_n !== 2 || (fs_t[1] - fs_t[0]) !== 112) begin
            failures++; $display("FAIL frame_start_period got=%0d(n=%0d) exp=112", fs_t[1] - fs_t[0], fs_n);
        end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_mode_shadow();
        bit solid_ok = 1'b1;
        rand_color  = 1'b0;
        vif.color_i = 24'h123456;
        vif.mode_i  = 2'd0;
        apply_reset(2);
        while (m_p < FRAME + 7) begin
            tick();
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL mode_pixel p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
            if (m_p == 2 * H_TOTAL) vif.mode_i = 2'd1;
            if (m_p < FRAME && vif.dvh_sync_o[2] && vif.vid_rgb_o !== 24'h123456) solid_ok = 1'b0;
            if (m_p == FRAME) begin
                checks++;
                if (vif.vid_rgb_o !== 24'hFFFFFF) begin
                    failures++; $display("FAIL bar_x0 got=%h exp=FFFFFF", vif.vid_rgb_o);
                end
            end
        end
        checks++;
        if (vif.vid_rgb_o !== 24'h000000) begin
            failures++; $display("FAIL bar_x7 got=%h exp=000000", vif.vid_rgb_o);
        end
        checks++;
        if (!solid_ok) begin
            failures++; $display("FAIL mode_shadow_solid got=changed exp=123456");
        end
        rand_color = 1'b1;
    endtask
`else
    task automatic test_passthrough();
        apply_reset(1);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            vif.rgb_i = 24'($urandom);
            #1;
            e_all = model_out(m_p, m_fc, m_mode, m_col, vif.rgb_i);
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL passthrough p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
        end
    endtask
`endif

    task automatic test_random();
        apply_reset(1);
        for (int i = 0; i < 3000; i++) begin
            vif.mode_i = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL random p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset(1);
        while (m_p < FRAME + 2 * H_TOTAL + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== e_all || vif.frame_cnt_o !== 16'd0) begin
            failures++; $display("FAIL mid_reset_state got=%h exp=%h", obs, e_all);
        end
        for (int i = 0; i < FRAME - 1; i++) begin
            tick();
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL post_reset_frame p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
            if (i == 0) begin
                checks++;
                if ({vif.frame_start_o, vif.x_o, vif.y_o, vif.frame_cnt_o} !== {1'b1, 12'd0, 12'd0, 16'd0}) begin
                    failures++;
                    $display("FAIL restart_origin got fs=%b x=%0d y=%0d fc=%0d exp fs=1 x=0 y=0 fc=0",
                             vif.frame_start_o, vif.x_o, vif.y_o, vif.frame_cnt_o);
                end
            end
        end
        checks++;
        if (vif.frame_cnt_o !== 16'd0) begin
            failures++; $display("FAIL frame_cnt_in_frame got=%0d exp=0", vif.frame_cnt_o);
        end
    endtask

    task automatic test_wrap();
        apply_reset(1);
        repeat (3) tick();
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_fc  = 16'hFFFF;
        e_all = model_out(m_p, m_fc, m_mode, m_col, vif.rgb_i);
        checks++;
        if (vif.frame_cnt_o !== 16'hFFFF) begin
            failures++; $display("FAIL wrap_preload got=%h exp=FFFF", vif.frame_cnt_o);
        end
        while (m_p < FRAME + H_TOTAL) begin
            tick();
            checks++;
            if (obs !== e_all) begin
                failures++; $display("FAIL wrap_pixel p=%0d got=%h exp=%h", m_p, obs, e_all);
            end
        end
        checks++;
        if (vif.frame_cnt_o !== 16'h0000) begin
            failures++; $display("FAIL frame_cnt_wrap got=%h exp=0000", vif.frame_cnt_o);
        end
    endtask

    initial begin
        rst         = 1'b1;
        vif.mode_i  = 2'd0;
        vif.color_i = 24'd0;
        vif.rgb_i   = 24'd0;
        test_reset();
        test_line();
        test_frame();
`ifdef TEST_PATTERN_EN
        test_mode_shadow();
`else
        test_passthrough();
`endif
        test_random();
        test_mid_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
